// File: rtl/aes_scan_pkg.sv
// Shared types and default sizing for the AES scan-test sequencer.
package aes_scan_pkg;

    localparam int unsigned DEF_KEY_W       = 128;
    localparam int unsigned DEF_DATA_W      = 128;
    localparam int unsigned DEF_CLK_DIV     = 4;
    localparam int unsigned DEF_RST_CYC     = 8;
    localparam int unsigned DEF_BSY_TIMEOUT = 4096;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST_ASIC,
        S_SHIFT_KEY,
        S_KEY_PULSE,
        S_SHIFT_DATA,
        S_DATA_PULSE,
        S_WAIT_BSY,
        S_SHIFT_OUT,
        S_FINISH
    } state_t;

endpackage

// File: rtl/aes_scan_sclk_gen.sv
// Scan clock divider: SCLK half-period of CLK_DIV cycles, forced low when disabled.
module sclk_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             wrap;

    assign wrap     = en && (div_cnt == DIV_W'(CLK_DIV - 1));
    // Strobes mark the CLK edge on which SCLK itself toggles.
    assign rise_stb = wrap && !sclk;
    assign fall_stb = wrap && sclk;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/aes_scan_sequencer.sv
// Turns one start request into the full AES ASIC scan sequence:
// reset, key load, data load, wait for BSY, ciphertext unload.
module aes_scan_sequencer
    import aes_scan_pkg::*;
#(
    parameter int unsigned KEY_W       = DEF_KEY_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned CLK_DIV     = DEF_CLK_DIV,
    parameter int unsigned RST_CYC     = DEF_RST_CYC,
    parameter int unsigned BSY_TIMEOUT = DEF_BSY_TIMEOUT
) (
    input  logic              CLK,
    input  logic              reset1,
    input  logic              start,
    input  logic [KEY_W-1:0]  key_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              SO,
    input  logic              BSY,
    output logic              RSTn1,
    output logic              EN1,
    output logic              SU1,
    output logic              SE1,
    output logic              SI1,
    output logic              SCLK,
    output logic              Krdy1,
    output logic              Drdy1,
    output logic [DATA_W-1:0] result_out,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);

    localparam int unsigned BIT_MAX = (KEY_W > DATA_W) ? KEY_W : DATA_W;
    localparam int unsigned BIT_W   = $clog2(BIT_MAX) + 1;
    localparam int unsigned RST_W   = (RST_CYC > 1) ? $clog2(RST_CYC + 1) : 1;
    localparam int unsigned TMO_W   = $clog2(BSY_TIMEOUT + 2);

    state_t            state, state_d;
    logic              start_q, start_rise;
    logic [KEY_W-1:0]  key_sr;
    logic [DATA_W-1:0] data_sr, res_sr;
    logic [BIT_W-1:0]  bit_cnt, bit_len;
    logic [RST_W-1:0]  rst_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              shifting, rise_stb, fall_stb, last_bit;

    assign start_rise = start && !start_q;
    assign shifting   = (state == S_SHIFT_KEY) || (state == S_SHIFT_DATA) || (state == S_SHIFT_OUT);
    assign bit_len    = (state == S_SHIFT_KEY) ? BIT_W'(KEY_W) : BIT_W'(DATA_W);
    // Leave on the last falling SCLK edge so every phase ends with SCLK low.
    assign last_bit   = fall_stb && (bit_cnt == (bit_len - BIT_W'(1)));
    assign busy       = (state != S_IDLE);

    sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk      (CLK),
        .rst      (reset1),
        .en       (shifting),
        .sclk     (SCLK),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    always_comb begin
        state_d = state;
        RSTn1   = 1'b1;
        EN1     = 1'b0;
        SU1     = 1'b0;
        SE1     = 1'b0;
        Krdy1   = 1'b0;
        Drdy1   = 1'b0;
        done    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_rise) state_d = S_RST_ASIC;
            end
            S_RST_ASIC: begin
                RSTn1 = 1'b0;
                if (rst_cnt == RST_W'(RST_CYC - 1)) state_d = S_SHIFT_KEY;
            end
            S_SHIFT_KEY: begin
                EN1 = 1'b1;
                SU1 = 1'b1;
                SE1 = 1'b1;
                if (last_bit) state_d = S_KEY_PULSE;
            end
            S_KEY_PULSE: begin
                EN1     = 1'b1;
                Krdy1   = 1'b1;
                state_d = S_SHIFT_DATA;
            end
            S_SHIFT_DATA: begin
                EN1 = 1'b1;
                SE1 = 1'b1;
                if (last_bit) state_d = S_DATA_PULSE;
            end
            S_DATA_PULSE: begin
                EN1     = 1'b1;
                Drdy1   = 1'b1;
                state_d = S_WAIT_BSY;
            end
            S_WAIT_BSY: begin
                EN1 = 1'b1;
                // First two cycles are a guard while the ASIC raises BSY.
                if (tmo_cnt >= TMO_W'(2)) begin
                    if (!BSY) state_d = S_SHIFT_OUT;
                    else if (tmo_cnt == TMO_W'(BSY_TIMEOUT + 1)) state_d = S_FINISH;
                end
            end
            S_SHIFT_OUT: begin
                EN1 = 1'b1;
                SE1 = 1'b1;
                if (last_bit) state_d = S_FINISH;
            end
            S_FINISH: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset1) begin
            state       <= S_IDLE;
            start_q     <= 1'b0;
            key_sr      <= '0;
            data_sr     <= '0;
            res_sr      <= '0;
            result_out  <= '0;
            timeout_err <= 1'b0;
            SI1         <= 1'b0;
            bit_cnt     <= '0;
            rst_cnt     <= '0;
            tmo_cnt     <= '0;
        end else begin
            state   <= state_d;
            start_q <= start;
            rst_cnt <= (state == S_RST_ASIC) ? rst_cnt + RST_W'(1) : '0;
            tmo_cnt <= (state == S_WAIT_BSY) ? tmo_cnt + TMO_W'(1) : '0;
            if (state_d != state) bit_cnt <= '0;
            else if (fall_stb)    bit_cnt <= bit_cnt + BIT_W'(1);

            case (state)
                S_IDLE: begin
                    SI1 <= 1'b0;
                    if (start_rise) begin
                        key_sr      <= key_in;
                        data_sr     <= data_in;
                        timeout_err <= 1'b0;
                    end
                end
                // MSB is presented one edge before the phase so it is stable for the first rise.
                S_RST_ASIC: begin
                    if (state_d == S_SHIFT_KEY) begin
                        SI1    <= key_sr[KEY_W-1];
                        key_sr <= key_sr << 1;
                    end
                end
                S_SHIFT_KEY: begin
                    if (fall_stb && !last_bit) begin
                        SI1    <= key_sr[KEY_W-1];
                        key_sr <= key_sr << 1;
                    end
                end
                S_KEY_PULSE: begin
                    SI1     <= data_sr[DATA_W-1];
                    data_sr <= data_sr << 1;
                end
                S_SHIFT_DATA: begin
                    if (fall_stb && !last_bit) begin
                        SI1     <= data_sr[DATA_W-1];
                        data_sr <= data_sr << 1;
                    end
                end
                S_WAIT_BSY: begin
                    if (state_d == S_FINISH) timeout_err <= 1'b1;
                end
                S_SHIFT_OUT: begin
                    if (rise_stb) res_sr <= {res_sr[DATA_W-2:0], SO};
                    if (last_bit) result_out <= res_sr;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_scan_sequencer.sv
// Scoreboard bench for aes_scan_sequencer with a behavioural ASIC model.
module tb_aes_scan_sequencer;

    localparam int unsigned KW = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned CD = 2;
    localparam int unsigned RC = 8;
    localparam int unsigned BT = 200;

    logic          CLK, reset1, start, SO, BSY;
    logic [KW-1:0] key_in;
    logic [DW-1:0] data_in;
    logic          RSTn1, EN1, SU1, SE1, SI1, SCLK, Krdy1, Drdy1, busy, done, timeout_err;
    logic [DW-1:0] result_out;

    aes_scan_sequencer #(
        .KEY_W       (KW),
        .DATA_W      (DW),
        .CLK_DIV     (CD),
        .RST_CYC     (RC),
        .BSY_TIMEOUT (BT)
    ) dut (
        .CLK         (CLK),
        .reset1      (reset1),
        .start       (start),
        .key_in      (key_in),
        .data_in     (data_in),
        .SO          (SO),
        .BSY         (BSY),
        .RSTn1       (RSTn1),
        .EN1         (EN1),
        .SU1         (SU1),
        .SE1         (SE1),
        .SI1         (SI1),
        .SCLK        (SCLK),
        .Krdy1       (Krdy1),
        .Drdy1       (Drdy1),
        .result_out  (result_out),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [KW-1:0] key;
        logic [DW-1:0] data;
        logic [DW-1:0] res;
        bit            stuck;
    } exp_t;

    exp_t          exp_q[$];
    int unsigned   n_checks = 0;
    int unsigned   n_pass   = 0;
    int unsigned   n_done   = 0;
    int unsigned   n_runs   = 0;
    logic [DW-1:0] model_result = '0;
    logic [DW-1:0] so_cur = '0;
    bit            bsy_stuck = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ASIC model: BSY high after Drdy1, SO presents the answer MSB first, advancing per SCLK rise.
    int unsigned bsy_left = 0;
    int unsigned so_idx   = 0;
    bit          after_drdy = 1'b0;
    logic        model_sclk_prev = 1'b0;
    always @(negedge CLK) begin
        if (busy !== 1'b1) begin
            after_drdy = 1'b0;
            bsy_left   = 0;
            BSY        = 1'b0;
            so_idx     = 0;
        end else if (Drdy1) begin
            after_drdy = 1'b1;
            so_idx     = 0;
            bsy_left   = 10;
            BSY        = 1'b1;
        end else begin
            if (!bsy_stuck && bsy_left > 0) begin
                bsy_left--;
                if (bsy_left == 0) BSY = 1'b0;
            end
            if (after_drdy && SE1 && SCLK && !model_sclk_prev && so_idx < DW) so_idx++;
        end
        model_sclk_prev = SCLK;
        SO = (after_drdy && so_idx < DW) ? so_cur[DW-1-so_idx] : 1'b0;
    end

    task automatic monitor();
        exp_t              e;
        int unsigned       cyc = 0, drdy_cyc = 0;
        int unsigned       rst_low = 0, krdy_n = 0, drdy_n = 0;
        int unsigned       key_cyc = 0, data_cyc = 0, out_cyc = 0, sclk_bad = 0, si_n = 0;
        bit                seen_drdy = 1'b0;
        logic              sclk_prev = 1'b0;
        logic [KW+DW-1:0]  si_vec = '0;
        forever begin
            @(negedge CLK);
            cyc++;
            if (busy !== 1'b1) begin
                rst_low = 0; krdy_n = 0; drdy_n = 0; key_cyc = 0; data_cyc = 0;
                out_cyc = 0; sclk_bad = 0; si_n = 0; seen_drdy = 1'b0; si_vec = '0;
                sclk_prev = 1'b0;
            end else begin
                if (!RSTn1) rst_low++;
                if (Krdy1) krdy_n++;
                if (Drdy1) begin drdy_n++; drdy_cyc = cyc; seen_drdy = 1'b1; end
                if (SE1 && SU1) key_cyc++;
                else if (SE1 && !seen_drdy) data_cyc++;
                else if (SE1) out_cyc++;
                if (!SE1 && SCLK) sclk_bad++;
                if (SCLK && !sclk_prev && SE1 && !seen_drdy) begin
                    si_vec = {si_vec[KW+DW-2:0], SI1};
                    si_n++;
                end
                sclk_prev = SCLK;
                if (done) begin
                    n_done++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_done: got done=1 expected no run pending");
                    end else begin
                        e = exp_q.pop_front();
                        check("result_out", 32'(result_out), 32'(e.res));
                        check("timeout_err", 32'(timeout_err), 32'(e.stuck));
                        check("si_bit_count", si_n, KW + DW);
                        check("si_bits", 32'(si_vec), 32'({e.key, e.data}));
                        check("rstn_low_cycles", rst_low, RC);
                        check("key_shift_cycles", key_cyc, 2 * CD * KW);
                        check("data_shift_cycles", data_cyc, 2 * CD * DW);
                        check("out_shift_cycles", out_cyc, e.stuck ? 0 : 2 * CD * DW);
                        check("krdy_cycles", krdy_n, 1);
                        check("drdy_cycles", drdy_n, 1);
                        check("sclk_outside_shift", sclk_bad, 0);
                        check("en1_at_done", 32'(EN1), 0);
                        if (e.stuck) check("timeout_latency", cyc - drdy_cyc, 3 + BT);
                    end
                end
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int unsigned n = 0;
        while (busy && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        check(name, 32'(busy), 0);
    endtask

    task automatic run_seq(input logic [KW-1:0] k, input logic [DW-1:0] d, input logic [DW-1:0] s,
                           input bit stuck, input bit hold, input bit poke);
        exp_t e;
        e.key = k; e.data = d; e.stuck = stuck;
        e.res = stuck ? model_result : s;
        model_result = e.res;
        exp_q.push_back(e);
        n_runs++;
        so_cur = s; bsy_stuck = stuck;
        key_in = k; data_in = d; start = 1'b1;
        @(negedge CLK);
        if (!hold) start = 1'b0;
        key_in  = KW'($urandom);
        data_in = DW'($urandom);
        if (poke) begin
            repeat (40) @(negedge CLK);
            start = 1'b1;
            repeat (3) @(negedge CLK);
            start = 1'b0;
        end
        wait_idle("run_completes");
        if (hold) begin
            repeat (20) @(negedge CLK);
            check("held_start_no_retrigger", 32'(busy), 0);
            start = 1'b0;
            @(negedge CLK);
        end
        if (poke) begin
            repeat (20) @(negedge CLK);
            check("busy_start_ignored", 32'(busy), 0);
        end
        repeat (3) @(negedge CLK);
    endtask

    initial begin
        int unsigned n;
        reset1 = 1'b1; start = 1'b0; key_in = '0; data_in = '0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge CLK);
        check("reset_outputs",
              32'({RSTn1, EN1, SU1, SE1, SI1, SCLK, Krdy1, Drdy1, busy, done, timeout_err}),
              32'(11'b100_0000_0000));
        check("reset_result", 32'(result_out), 0);
        reset1 = 1'b0;
        repeat (2) @(negedge CLK);

        run_seq(8'hA5, 8'h3C, 8'hC3, 1'b0, 1'b0, 1'b0);
        run_seq(KW'($urandom), DW'($urandom), DW'($urandom), 1'b1, 1'b0, 1'b0);

        // Abort during the data shift; no result may survive.
        bsy_stuck = 1'b0;
        key_in = KW'($urandom); data_in = DW'($urandom); start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        n = 0;
        while (!(SE1 && !SU1) && n < 500) begin
            @(negedge CLK);
            n++;
        end
        check("reached_shift_data", 32'(SE1 && !SU1), 1);
        repeat (5) @(negedge CLK);
        reset1 = 1'b1;
        @(negedge CLK);
        check("abort_outputs",
              32'({RSTn1, EN1, SU1, SE1, SI1, SCLK, Krdy1, Drdy1, busy, done, timeout_err}),
              32'(11'b100_0000_0000));
        check("abort_result", 32'(result_out), 0);
        reset1 = 1'b0;
        model_result = '0;
        repeat (2) @(negedge CLK);

        run_seq(KW'($urandom), DW'($urandom), DW'($urandom), 1'b0, 1'b0, 1'b0);
        run_seq(KW'($urandom), DW'($urandom), DW'($urandom), 1'b0, 1'b1, 1'b0);
        run_seq(KW'($urandom), DW'($urandom), DW'($urandom), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            run_seq(KW'($urandom), DW'($urandom), DW'($urandom), 1'b0, 1'b0, 1'b0);
        run_seq(KW'($urandom), DW'($urandom), DW'($urandom), 1'b1, 1'b0, 1'b0);
        run_seq(KW'($urandom), DW'($urandom), DW'($urandom), 1'b0, 1'b0, 1'b0);

        repeat (10) @(negedge CLK);
        check("done_count", n_done, n_runs);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
